// File: rtl/regfile_port_sched.sv
// Write/read port scheduler for a 1W/2R register file: arbitrates two writers and one reader.
// Optional REGFILE_SCHED_ZERO_REG_EN: address-0 writes are accepted but never issued.
module regfile_port_sched #(
   parameter int unsigned MAX_WR_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wa_valid,
   output logic        wa_ready,
   input  logic [4:0]  wa_addr,
   input  logic [31:0] wa_data,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        rd_valid,
   output logic        rd_ready,
   input  logic [4:0]  rd_addr1,
   input  logic [4:0]  rd_addr2,
   output logic        rd_done,
   output logic [31:0] rd_data1,
   output logic [31:0] rd_data2,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2
);

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} issue_t;

   localparam logic       RR_A      = 1'b0;
   localparam logic       RR_B      = 1'b1;
   localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);

   issue_t      state_q, state_d;
   logic [3:0]  burst_cnt_q, burst_cnt_d;
   logic        rr_last_q, rr_last_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  raddr1_q, raddr1_d;
   logic [4:0]  raddr2_q, raddr2_d;
   logic        rd_done_q, rd_done_d;
   logic [31:0] rd_data1_q, rd_data1_d;
   logic [31:0] rd_data2_q, rd_data2_d;

   logic        wr_any;
   logic        wr_gnt;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   // Arbitration: the pending read wins only when no write is pending or the burst limit is hit.
   always_comb begin
      wa_ready = 1'b0;
      wb_ready = 1'b0;
      rd_ready = 1'b0;
      wr_any   = wa_valid | wb_valid;
      if (!rst) begin
         if (rd_valid && (!wr_any || burst_cnt_q == BURST_MAX)) begin
            rd_ready = 1'b1;
         end else if (wa_valid && (!wb_valid || rr_last_q == RR_B)) begin
            wa_ready = 1'b1;
         end else if (wb_valid) begin
            wb_ready = 1'b1;
         end
      end
      wr_gnt  = wa_ready | wb_ready;
      wr_addr = wa_ready ? wa_addr : wb_addr;
      wr_data = wa_ready ? wa_data : wb_data;
   end

   always_comb begin
      state_d     = ST_IDLE;
      burst_cnt_d = burst_cnt_q;
      rr_last_d   = rr_last_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      raddr1_d    = raddr1_q;
      raddr2_d    = raddr2_q;
      rd_done_d   = (state_q == ST_RD);
      rd_data1_d  = rd_data1_q;
      rd_data2_d  = rd_data2_q;

      if (wr_gnt) begin
         rr_last_d = wb_ready ? RR_B : RR_A;
`ifdef REGFILE_SCHED_ZERO_REG_EN
         if (wr_addr != 5'd0) begin
            state_d = ST_WR;
            waddr_d = wr_addr;
            wdata_d = wr_data;
         end
`else
         state_d = ST_WR;
         waddr_d = wr_addr;
         wdata_d = wr_data;
`endif
      end else if (rd_ready) begin
         state_d  = ST_RD;
         raddr1_d = rd_addr1;
         raddr2_d = rd_addr2;
      end

      // Burst counter only measures writes that overtake a waiting read.
      if (!rd_valid || rd_ready) begin
         burst_cnt_d = 4'd0;
      end else if (wr_gnt && burst_cnt_q != BURST_MAX) begin
         burst_cnt_d = burst_cnt_q + 4'd1;
      end

      if (state_q == ST_RD) begin
         rd_data1_d = rf_rdata1;
         rd_data2_d = rf_rdata2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= 4'd0;
         rr_last_q   <= RR_B;
         waddr_q     <= 5'd0;
         wdata_q     <= 32'd0;
         raddr1_q    <= 5'd0;
         raddr2_q    <= 5'd0;
         rd_done_q   <= 1'b0;
         rd_data1_q  <= 32'd0;
         rd_data2_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rr_last_q   <= rr_last_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         raddr1_q    <= raddr1_d;
         raddr2_q    <= raddr2_d;
         rd_done_q   <= rd_done_d;
         rd_data1_q  <= rd_data1_d;
         rd_data2_q  <= rd_data2_d;
      end
   end

   assign rf_we     = (state_q == ST_WR);
   assign rf_waddr  = waddr_q;
   assign rf_wdata  = wdata_q;
   assign rf_raddr1 = raddr1_q;
   assign rf_raddr2 = raddr2_q;
   assign rd_done   = rd_done_q;
   assign rd_data1  = rd_data1_q;
   assign rd_data2  = rd_data2_q;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Scoreboard bench for regfile_port_sched with a behavioural 32x32 register file attached.
module tb_regfile_port_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        wa_valid, wa_ready, wb_valid, wb_ready, rd_valid, rd_ready, rd_done;
   logic [4:0]  wa_addr, wb_addr, rd_addr1, rd_addr2;
   logic [31:0] wa_data, wb_data, rd_data1, rd_data2;
   logic        rf_we;
   logic [4:0]  rf_waddr, rf_raddr1, rf_raddr2;
   logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;

   typedef struct packed {logic [4:0] addr; logic [31:0] data;} wr_exp_t;
   typedef struct packed {logic [31:0] d1; logic [31:0] d2;} rd_exp_t;

   wr_exp_t     exp_wr_q[$];
   rd_exp_t     exp_rd_q[$];
   logic [31:0] mem [32];
   logic [31:0] shadow [32];
   int          n_cmp = 0;
   int          n_err = 0;

   regfile_port_sched #(.MAX_WR_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_done(rd_done), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
   );

   always #5 clk = ~clk;

   // Register file: synchronous write, read outputs forced to zero while writing.
   always @(posedge clk) if (rf_we) mem[rf_waddr] <= rf_wdata;
   assign rf_rdata1 = rf_we ? 32'd0 : mem[rf_raddr1];
   assign rf_rdata2 = rf_we ? 32'd0 : mem[rf_raddr2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
      exp_wr_q.push_back('{addr: a, data: d});
      shadow[a] = d;
   endtask

   task automatic push_rd(input logic [4:0] a1, input logic [4:0] a2);
      exp_rd_q.push_back('{d1: shadow[a1], d2: shadow[a2]});
   endtask

   // Output monitor: every issued write and every read completion is matched in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (rf_we) begin
            if (exp_wr_q.size() == 0) begin
               check("wr_unexpected", {31'd0, rf_we}, 32'd0);
            end else begin
               wr_exp_t w;
               w = exp_wr_q.pop_front();
               check("wr_addr", {27'd0, rf_waddr}, {27'd0, w.addr});
               check("wr_data", rf_wdata, w.data);
            end
         end
         if (rd_done) begin
            if (exp_rd_q.size() == 0) begin
               check("rd_unexpected", {31'd0, rd_done}, 32'd0);
            end else begin
               rd_exp_t r;
               r = exp_rd_q.pop_front();
               check("rd_data1", rd_data1, r.d1);
               check("rd_data2", rd_data2, r.d2);
            end
         end
      end
   end

   task automatic chk_ready(input string tag, input logic ea, input logic eb, input logic er);
      check({tag, "_wa_ready"}, {31'd0, wa_ready}, {31'd0, ea});
      check({tag, "_wb_ready"}, {31'd0, wb_ready}, {31'd0, eb});
      check({tag, "_rd_ready"}, {31'd0, rd_ready}, {31'd0, er});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]    = 32'd0;
         shadow[i] = 32'd0;
      end

      // Reset with every requester asserting valid.
      rst = 1'b1;
      wa_valid = 1'b1; wa_addr = 5'd1; wa_data = 32'h1111_0001;
      wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h2222_0002;
      rd_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
      @(posedge clk);
      @(negedge clk);
      chk_ready("rst", 1'b0, 1'b0, 1'b0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      check("rst_rd_done", {31'd0, rd_done}, 32'd0);
      check("rst_rd_data1", rd_data1, 32'd0);
      check("rst_rd_data2", rd_data2, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_valid = 1'b0;

      // Round-robin: A has first priority after reset.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            chk_ready("rr", 1'b1, 1'b0, 1'b0);
            push_wr(5'd1, 32'h1111_0001);
         end else begin
            chk_ready("rr", 1'b0, 1'b1, 1'b0);
            push_wr(5'd2, 32'h2222_0002);
         end
         next_cycle();
      end
      wa_valid = 1'b0; wb_valid = 1'b0;
      repeat (2) next_cycle();

      // Write then read of the same register.
      wa_valid = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk_ready("wr5", 1'b1, 1'b0, 1'b0);
      push_wr(5'd5, 32'hDEAD_BEEF);
      next_cycle();
      wa_valid = 1'b0;
      rd_valid = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd0;
      @(negedge clk);
      check("wr5_rf_we", {31'd0, rf_we}, 32'd1);
      chk_ready("rd5", 1'b0, 1'b0, 1'b1);
      push_rd(5'd5, 5'd0);
      next_cycle();
      rd_valid = 1'b0;
      @(negedge clk);
      check("rd5_raddr1", {27'd0, rf_raddr1}, 32'd5);
      check("rd5_done_early", {31'd0, rd_done}, 32'd0);
      next_cycle();
      @(negedge clk);
      check("rd5_done", {31'd0, rd_done}, 32'd1);
      next_cycle();
      @(negedge clk);
      check("rd5_done_pulse", {31'd0, rd_done}, 32'd0);
      check("rd5_hold", rd_data1, 32'hDEAD_BEEF);
      next_cycle();

      // Starvation limit: four writes overtake the read, then it is served.
      wa_valid = 1'b1; wa_addr = 5'd7;
      rd_valid = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd3;
      for (int i = 0; i < 6; i++) begin
         wa_data = 32'hA000_0000 + i;
         @(negedge clk);
         if (i == 4) begin
            chk_ready("burst", 1'b0, 1'b0, 1'b1);
            push_rd(5'd7, 5'd3);
         end else begin
            chk_ready("burst", 1'b1, 1'b0, 1'b0);
            push_wr(5'd7, 32'hA000_0000 + i);
         end
         next_cycle();
         if (i == 4) rd_valid = 1'b0;
      end
      wa_valid = 1'b0;
      repeat (3) next_cycle();

      // Register 0 write followed by a read of it.
      wa_valid = 1'b1; wa_addr = 5'd0; wa_data = 32'h0000_1234;
      @(negedge clk);
      chk_ready("z_wr", 1'b1, 1'b0, 1'b0);
`ifndef REGFILE_SCHED_ZERO_REG_EN
      push_wr(5'd0, 32'h0000_1234);
`endif
      next_cycle();
      wa_valid = 1'b0;
      rd_valid = 1'b1; rd_addr1 = 5'd0; rd_addr2 = 5'd1;
      @(negedge clk);
`ifdef REGFILE_SCHED_ZERO_REG_EN
      check("z_rf_we", {31'd0, rf_we}, 32'd0);
`else
      check("z_rf_we", {31'd0, rf_we}, 32'd1);
`endif
      chk_ready("z_rd", 1'b0, 1'b0, 1'b1);
      push_rd(5'd0, 5'd1);
      next_cycle();
      rd_valid = 1'b0;
      repeat (3) next_cycle();

      // Reset arrives the cycle after a read grant: the read must vanish.
      rd_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
      @(negedge clk);
      chk_ready("mr_rd", 1'b0, 1'b0, 1'b1);
      next_cycle();
      rd_valid = 1'b0;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      wa_valid = 1'b1; wa_addr = 5'd3; wa_data = 32'h3333_0003;
      wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444_0004;
      @(negedge clk);
      check("mr_rd_done", {31'd0, rd_done}, 32'd0);
      check("mr_rd_data1", rd_data1, 32'd0);
      check("mr_rd_data2", rd_data2, 32'd0);
      check("mr_rf_we", {31'd0, rf_we}, 32'd0);
      chk_ready("mr_rr", 1'b1, 1'b0, 1'b0);
      push_wr(5'd3, 32'h3333_0003);
      next_cycle();
      wa_valid = 1'b0; wb_valid = 1'b0;
      repeat (4) next_cycle();

      check("wr_q_left", exp_wr_q.size(), 32'd0);
      check("rd_q_left", exp_rd_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
